// File: rtl/systolic_os_tile.sv
// systolic_os_tile: output-stationary ROWS x COLS MAC tile with internal operand skew,
// valid/ready operand streaming and a requantising one-row-per-handshake drain.
module systolic_os_tile #(
  parameter int ROWS         = 8,
  parameter int COLS         = 8,
  parameter int DATA_WIDTH   = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int K_BITS       = 9,
  parameter int ACC_WIDTH    = DATA_WIDTH + WEIGHT_WIDTH + K_BITS,
  parameter int OUT_WIDTH    = 8,
  parameter int SHIFT_BITS   = 5
) (
  input  logic                         clk,
  input  logic                         srstn,
  input  logic                         start,
  input  logic [K_BITS-1:0]            k_len,
  input  logic [SHIFT_BITS-1:0]        shift,
  input  logic                         relu_en,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [ROWS*DATA_WIDTH-1:0]   in_data,
  input  logic [COLS*WEIGHT_WIDTH-1:0] in_weight,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [COLS*OUT_WIDTH-1:0]    out_row,
  output logic [$clog2(ROWS)-1:0]      out_row_idx,
  output logic                         busy,
  output logic                         done
);
  localparam int PW = DATA_WIDTH + WEIGHT_WIDTH;
  // wide enough that the rounding constant for any shift cannot overflow
  localparam int EW = ACC_WIDTH + 2 ** SHIFT_BITS;
  localparam int FW = $clog2(ROWS + COLS);
  localparam int IW = $clog2(ROWS);
  localparam logic signed [EW-1:0] OMAX = EW'(2 ** (OUT_WIDTH - 1) - 1);
  localparam logic signed [EW-1:0] OMIN = -OMAX - 1;
  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;
  state_t state, nstate;
  logic [K_BITS-1:0] k_q, beat_cnt;
  logic [SHIFT_BITS-1:0] shift_q;
  logic relu_q, hs, clr, run, out_hs, last_row;
  logic [FW-1:0] fl_cnt;
  logic [IW-1:0] row_sel;
  logic signed [DATA_WIDTH-1:0] d_inj [ROWS];
  logic signed [DATA_WIDTH-1:0] d_sk [ROWS];
  logic signed [DATA_WIDTH-1:0] a [ROWS][COLS];
  logic signed [WEIGHT_WIDTH-1:0] w_inj [COLS];
  logic signed [WEIGHT_WIDTH-1:0] w_sk [COLS];
  logic signed [WEIGHT_WIDTH-1:0] b [ROWS][COLS];
  logic signed [PW-1:0] prod [ROWS][COLS];
  logic signed [ACC_WIDTH-1:0] acc [ROWS][COLS];
  logic [COLS*OUT_WIDTH-1:0] row_q;

  assign in_ready = state == LOAD;
  assign busy     = state != IDLE;
  assign hs       = in_valid && in_ready;
  assign clr      = state == IDLE && start;
  assign run      = state == LOAD || state == FLUSH;
  assign out_hs   = out_valid && out_ready;
  assign last_row = out_row_idx == IW'(ROWS - 1);
  assign row_sel  = out_valid ? out_row_idx + 1'b1 : '0;

  always_ff @(posedge clk)
    if (!srstn) state <= IDLE;
    else state <= nstate;

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (start) nstate = k_len == '0 ? FLUSH : LOAD;
      LOAD:    if (hs && beat_cnt == k_q - 1'b1) nstate = FLUSH;
      FLUSH:   if (fl_cnt == FW'(ROWS + COLS - 2)) nstate = DRAIN;
      DRAIN:   if (out_hs && last_row) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk)
    if (!srstn) begin
      k_q         <= '0;
      shift_q     <= '0;
      relu_q      <= 1'b0;
      beat_cnt    <= '0;
      fl_cnt      <= '0;
      out_valid   <= 1'b0;
      out_row     <= '0;
      out_row_idx <= '0;
      done        <= 1'b0;
    end else begin
      done   <= out_hs && last_row;
      fl_cnt <= state == FLUSH ? fl_cnt + 1'b1 : '0;
      if (clr) begin
        k_q      <= k_len;
        shift_q  <= shift;
        relu_q   <= relu_en;
        beat_cnt <= '0;
      end else if (hs) beat_cnt <= beat_cnt + 1'b1;
      if (out_hs && last_row) out_valid <= 1'b0;
      else if (state == DRAIN && (!out_valid || out_hs)) begin
        out_valid   <= 1'b1;
        out_row     <= row_q;
        out_row_idx <= row_sel;
      end
    end

  // idle cycles inject zeros so the diagonal wavefront stays aligned
  for (genvar r = 0; r < ROWS; r++) begin : g_dsk
    assign d_inj[r] = hs ? in_data[r*DATA_WIDTH +: DATA_WIDTH] : '0;
    if (r == 0) begin : g_0
      assign d_sk[r] = d_inj[r];
    end else begin : g_n
      logic signed [DATA_WIDTH-1:0] sk [r];
      always_ff @(posedge clk)
        if (!srstn || clr) sk <= '{default: '0};
        else if (run) begin
          sk[0] <= d_inj[r];
          for (int i = 1; i < r; i++) sk[i] <= sk[i-1];
        end
      assign d_sk[r] = sk[r-1];
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_wsk
    assign w_inj[c] = hs ? in_weight[c*WEIGHT_WIDTH +: WEIGHT_WIDTH] : '0;
    if (c == 0) begin : g_0
      assign w_sk[c] = w_inj[c];
    end else begin : g_n
      logic signed [WEIGHT_WIDTH-1:0] sk [c];
      always_ff @(posedge clk)
        if (!srstn || clr) sk <= '{default: '0};
        else if (run) begin
          sk[0] <= w_inj[c];
          for (int i = 1; i < c; i++) sk[i] <= sk[i-1];
        end
      assign w_sk[c] = sk[c-1];
    end
  end

  always_comb
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) prod[r][c] = a[r][c] * b[r][c];

  always_ff @(posedge clk)
    if (!srstn || clr) begin
      a   <= '{default: '0};
      b   <= '{default: '0};
      acc <= '{default: '0};
    end else if (run) begin
      for (int r = 0; r < ROWS; r++) begin
        a[r][0] <= d_sk[r];
        for (int c = 1; c < COLS; c++) a[r][c] <= a[r][c-1];
      end
      for (int c = 0; c < COLS; c++) begin
        b[0][c] <= w_sk[c];
        for (int r = 1; r < ROWS; r++) b[r][c] <= b[r-1][c];
      end
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) acc[r][c] <= acc[r][c] + ACC_WIDTH'(prod[r][c]);
    end

  function automatic logic [OUT_WIDTH-1:0] requant(input logic signed [ACC_WIDTH-1:0] v);
    logic signed [EW-1:0] x;
    x = EW'(v);
    x = shift_q == '0 ? x : x + (EW'(1) << (shift_q - 1'b1));
    x = x >>> shift_q;
    x = relu_q && x < 0 ? '0 : x;
    return x > OMAX ? OUT_WIDTH'(OMAX) : x < OMIN ? OUT_WIDTH'(OMIN) : x[OUT_WIDTH-1:0];
  endfunction

  always_comb
    for (int c = 0; c < COLS; c++) row_q[c*OUT_WIDTH +: OUT_WIDTH] = requant(acc[row_sel][c]);
endmodule

// File: tb/tb_systolic_os_tile.sv
// tb_systolic_os_tile: randomized and directed jobs on a 4x4 tile checked against a matrix-product model.
module tb_systolic_os_tile;
  localparam int R = 4;
  localparam int C = 4;
  logic clk = 0, srstn = 0, start = 0, relu_en = 0, in_valid = 0, out_ready = 0;
  logic [8:0] k_len = '0;
  logic [4:0] shift = '0;
  logic [31:0] in_data = '0, in_weight = '0;
  logic in_ready, out_valid, busy, done;
  logic [31:0] out_row;
  logic [1:0] out_row_idx;
  int n_vec = 0, n_err = 0, cyc = 0;
  int d[64][4];
  int w[64][4];
  logic [31:0] got_row[4];
  logic [1:0] got_idx[4];
  int nrows, hold_bad, lat;
  logic done_after, done_later;

  systolic_os_tile #(.ROWS(R), .COLS(C)) dut (
    .clk(clk), .srstn(srstn), .start(start), .k_len(k_len), .shift(shift), .relu_en(relu_en),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_weight(in_weight),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row), .out_row_idx(out_row_idx),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int model(int r, int c, int k, int sh, bit relu);
    longint s = 0;
    for (int i = 0; i < k; i++) s += longint'(d[i][r]) * longint'(w[i][c]);
    if (sh > 0) s += longint'(1) << (sh - 1);
    s = s >>> sh;
    if (relu && s < 0) s = 0;
    return s > 127 ? 127 : s < -128 ? -128 : int'(s);
  endfunction

  function automatic logic [31:0] exp_row(int r, int k, int sh, bit relu);
    logic [31:0] e;
    for (int c = 0; c < C; c++) e[c*8 +: 8] = 8'(model(r, c, k, sh, relu));
    return e;
  endfunction

  // vmode: 0 always valid, 1 toggling, 2 random; rmode: 0 always ready, 1 stall 5 at row 1, 2 random
  task automatic run_job(input int k, input int sh, input bit relu, input int vmode, input int rmode, input bit noisy);
    int idx = 0, budget = 0, t_last = -1, t_first = -1, stall = 0;
    bit v = 0, hs, pstall = 0;
    logic [31:0] prow = '0;
    logic [1:0] pidx = '0;
    nrows = 0; hold_bad = 0; lat = -1;
    for (int r = 0; r < R; r++) begin got_row[r] = 'x; got_idx[r] = 'x; end
    @(negedge clk);
    start = 1; k_len = 9'(k); shift = 5'(sh); relu_en = relu;
    @(negedge clk);
    start = 0;
    while (idx < k && budget < 2000) begin
      v = vmode == 0 ? 1'b1 : vmode == 1 ? !v : 1'($urandom_range(0, 1));
      in_valid = v;
      for (int r = 0; r < R; r++) in_data[r*8 +: 8] = 8'(d[idx][r]);
      for (int c = 0; c < C; c++) in_weight[c*8 +: 8] = 8'(w[idx][c]);
      if (noisy) begin
        start = 1'($urandom_range(0, 1)); k_len = 9'($urandom); shift = 5'($urandom); relu_en = 1'($urandom);
      end
      hs = v && in_ready;
      if (hs && idx == k - 1) t_last = cyc;
      @(negedge clk);
      budget++;
      if (hs) idx++;
    end
    in_valid = 0; start = 0; in_data = '0; in_weight = '0;
    while (nrows < R && budget < 4000) begin
      if (pstall && (out_valid !== 1'b1 || out_row !== prow || out_row_idx !== pidx)) hold_bad++;
      if (out_valid === 1'b1 && t_first < 0) t_first = cyc;
      out_ready = rmode == 0 ? 1'b1 : rmode == 1 ? !(out_valid && out_row_idx == 2'd1 && stall < 5)
                                                  : 1'($urandom_range(0, 1));
      if (rmode == 1 && !out_ready) stall++;
      pstall = out_valid && !out_ready; prow = out_row; pidx = out_row_idx;
      if (out_valid === 1'b1 && out_ready) begin
        got_row[nrows] = out_row; got_idx[nrows] = out_row_idx; nrows++;
      end
      @(negedge clk);
      budget++;
    end
    out_ready = 0;
    done_after = done;
    @(negedge clk);
    done_later = done;
    if (t_last >= 0 && t_first >= 0) lat = t_first - t_last;
  endtask

  task automatic test_reset();
    n_vec++;
    if ({in_ready, out_valid, busy, done, out_row, out_row_idx} !== '0) begin
      n_err++;
      $display("FAIL reset: rdy=%b ov=%b busy=%b done=%b row=%h idx=%0d, want all 0",
               in_ready, out_valid, busy, done, out_row, out_row_idx);
    end
  endtask

  task automatic test_ones();
    for (int i = 0; i < 3; i++) for (int j = 0; j < 4; j++) begin d[i][j] = 1; w[i][j] = 2; end
    run_job(3, 0, 0, 0, 0, 0);
    for (int r = 0; r < R; r++) begin
      n_vec++;
      if ({got_idx[r], got_row[r]} !== {2'(r), 32'h06060606}) begin
        n_err++; $display("FAIL ones row %0d: got idx %0d row %h, want idx %0d row 06060606", r, got_idx[r], got_row[r], r);
      end
    end
    n_vec++;
    if (lat !== R + C + 1) begin n_err++; $display("FAIL latency: got %0d want %0d", lat, R + C + 1); end
    n_vec++;
    if ({done_after, done_later, busy} !== 3'b100) begin
      n_err++; $display("FAIL done pulse: got %b%b busy %b, want 10 busy 0", done_after, done_later, busy);
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) begin d[i][j] = 127; w[i][j] = 127; end
    run_job(4, 8, 0, 0, 0, 0);
    for (int r = 0; r < R; r++) begin
      n_vec++;
      if ({got_idx[r], got_row[r]} !== {2'(r), 32'h7f7f7f7f}) begin
        n_err++; $display("FAIL saturate row %0d: got idx %0d row %h, want row 7f7f7f7f", r, got_idx[r], got_row[r]);
      end
    end
  endtask

  task automatic test_relu_neg();
    int sh[3] = '{0, 0, 2};
    bit rl[3] = '{0, 1, 0};
    logic [31:0] want[3] = '{32'hf6f6f6f6, 32'h00000000, 32'hfefefefe};
    for (int i = 0; i < 2; i++) for (int j = 0; j < 4; j++) begin d[i][j] = -1; w[i][j] = 5; end
    for (int m = 0; m < 3; m++) begin
      run_job(2, sh[m], rl[m], 0, 0, 0);
      for (int r = 0; r < R; r++) begin
        n_vec++;
        if ({got_idx[r], got_row[r]} !== {2'(r), want[m]}) begin
          n_err++; $display("FAIL relu_neg case %0d row %0d: got idx %0d row %h, want row %h", m, r, got_idx[r], got_row[r], want[m]);
        end
      end
    end
  endtask

  task automatic test_bubbles();
    for (int i = 0; i < 3; i++) for (int j = 0; j < 4; j++) begin d[i][j] = j + 1; w[i][j] = j + 1; end
    run_job(3, 0, 0, 1, 0, 0);
    for (int r = 0; r < R; r++) begin
      logic [31:0] e;
      for (int c = 0; c < C; c++) e[c*8 +: 8] = 8'(3 * (r + 1) * (c + 1));
      n_vec++;
      if ({got_idx[r], got_row[r]} !== {2'(r), e}) begin
        n_err++; $display("FAIL bubbles row %0d: got idx %0d row %h, want row %h", r, got_idx[r], got_row[r], e);
      end
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 3; i++) for (int j = 0; j < 4; j++) begin
      d[i][j] = int'($urandom_range(0, 20)) - 10; w[i][j] = int'($urandom_range(0, 20)) - 10;
    end
    run_job(3, 1, 0, 0, 1, 0);
    for (int r = 0; r < R; r++) begin
      n_vec++;
      if ({got_idx[r], got_row[r]} !== {2'(r), exp_row(r, 3, 1, 0)}) begin
        n_err++; $display("FAIL backpressure row %0d: got idx %0d row %h, want row %h", r, got_idx[r], got_row[r], exp_row(r, 3, 1, 0));
      end
    end
    n_vec++;
    if (hold_bad !== 0) begin n_err++; $display("FAIL hold stable: %0d unstable stall cycles, want 0", hold_bad); end
  endtask

  task automatic test_zero_len();
    run_job(0, 0, 0, 0, 0, 0);
    for (int r = 0; r < R; r++) begin
      n_vec++;
      if ({got_idx[r], got_row[r]} !== {2'(r), 32'h0}) begin
        n_err++; $display("FAIL zero_len row %0d: got idx %0d row %h, want row 0", r, got_idx[r], got_row[r]);
      end
    end
    n_vec++;
    if ({done_after, done_later} !== 2'b10) begin n_err++; $display("FAIL zero_len done: got %b%b want 10", done_after, done_later); end
  endtask

  task automatic test_reset_midjob();
    @(negedge clk);
    start = 1; k_len = 9'd3; shift = 0; relu_en = 0;
    @(negedge clk);
    start = 0; in_valid = 1; in_data = 32'h55667788; in_weight = 32'h7f7f7f7f;
    repeat (2) @(negedge clk);
    srstn = 0; in_valid = 0;
    @(negedge clk);
    n_vec++;
    if ({in_ready, out_valid, busy, done, out_row, out_row_idx} !== '0) begin
      n_err++; $display("FAIL midjob reset: rdy=%b ov=%b busy=%b row=%h, want all 0", in_ready, out_valid, busy, out_row);
    end
    @(negedge clk);
    srstn = 1;
    for (int i = 0; i < 3; i++) for (int j = 0; j < 4; j++) begin d[i][j] = 1; w[i][j] = 1; end
    run_job(3, 0, 0, 0, 0, 0);
    for (int r = 0; r < R; r++) begin
      n_vec++;
      if ({got_idx[r], got_row[r]} !== {2'(r), 32'h03030303}) begin
        n_err++; $display("FAIL after reset row %0d: got idx %0d row %h, want row 03030303", r, got_idx[r], got_row[r]);
      end
    end
  endtask

  task automatic test_random();
    for (int j = 0; j < 8; j++) begin
      int k = $urandom_range(1, 40);
      int sh = $urandom_range(0, 20);
      bit rl = 1'($urandom_range(0, 1));
      for (int i = 0; i < k; i++) for (int l = 0; l < 4; l++) begin
        d[i][l] = int'($urandom_range(0, 255)) - 128; w[i][l] = int'($urandom_range(0, 255)) - 128;
      end
      run_job(k, sh, rl, 2, 2, 1);
      for (int r = 0; r < R; r++) begin
        n_vec++;
        if ({got_idx[r], got_row[r]} !== {2'(r), exp_row(r, k, sh, rl)}) begin
          n_err++; $display("FAIL random job %0d row %0d: got idx %0d row %h, want row %h", j, r, got_idx[r], got_row[r], exp_row(r, k, sh, rl));
        end
      end
      n_vec++;
      if (hold_bad !== 0 || {done_after, done_later} !== 2'b10) begin
        n_err++; $display("FAIL random job %0d handshake: unstable %0d done %b%b, want 0 and 10", j, hold_bad, done_after, done_later);
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    srstn = 1;
    test_ones();
    test_saturate();
    test_relu_neg();
    test_bubbles();
    test_backpressure();
    test_zero_len();
    test_reset_midjob();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
